// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM-stage load/store path and DataMem.
// Buffers stores in a FIFO, drains them in load-free cycles, forwards to loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [DW-1:0]          cpu_wdata,
    input  logic                   cpu_write,
    input  logic                   cpu_read,
    input  logic                   fence,
    output logic [DW-1:0]          cpu_rdata,
    output logic                   cpu_stall,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [AW-1:0]          mem_access_addr,
    output logic [DW-1:0]          mem_write_data,
    output logic                   mem_write_en,
    output logic                   mem_read,
    input  logic [DW-1:0]          mem_read_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          blocked;
    logic          load;
    logic          drain;
    logic          enq;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic [PW-1:0] fwd_idx;

    // A pending fence holds off every CPU request until the buffer is empty.
    // Drain is suppressed under reset so discarded entries never reach DataMem.
    assign blocked = fence & (count_q != '0);
    assign load    = cpu_read & ~blocked;
    assign drain   = ~rst & ~load & (count_q != '0);
    assign enq     = cpu_write & ~cpu_read & (count_q != FULL) & ~blocked;

    assign cpu_stall = (cpu_write & (count_q == FULL))
                     | (cpu_read & cpu_write)
                     | ((cpu_read | cpu_write) & fence & (count_q != '0));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PW'(k);
            if (CW'(k) < count_q && addr_q[fwd_idx] == cpu_addr) begin
                hit      = 1'b1;
                hit_data = data_q[fwd_idx];
            end
        end
    end

    // DataMem port arbitration: load first, then drain, else idle.
    always_comb begin
        cpu_rdata       = '0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        if (load) begin
            if (hit) begin
                cpu_rdata = hit_data;
            end else begin
                mem_access_addr = cpu_addr;
                mem_read        = 1'b1;
                cpu_rdata       = mem_read_data;
            end
        end else if (drain) begin
            mem_access_addr = addr_q[head_q];
            mem_write_data  = data_q[head_q];
            mem_write_en    = 1'b1;
        end
    end

    // Next-state pointers and occupancy.
    always_comb begin
        head_d  = head_q + PW'(drain);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q;
        if (enq && !drain) begin
            count_d = count_q + CW'(1);
        end else if (drain && !enq) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers; reset discards all pending stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; validity is implied by head and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= cpu_addr;
            data_q[tail_q] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based reference model.
// Includes a behavioural DataMem attached to the DataMem port.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [AW-1:0]          cpu_addr = '0;
    logic [DW-1:0]          cpu_wdata = '0;
    logic                   cpu_write = 1'b0;
    logic                   cpu_read = 1'b0;
    logic                   fence = 1'b0;
    logic [DW-1:0]          cpu_rdata;
    logic                   cpu_stall;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic [AW-1:0]          mem_access_addr;
    logic [DW-1:0]          mem_write_data;
    logic                   mem_write_en;
    logic                   mem_read;
    logic [DW-1:0]          mem_read_data;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] ref_mem [65536];
    logic [DW-1:0] dmem [65536];

    int vectors = 0;
    int miscompares = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_write(cpu_write),
        .cpu_read(cpu_read),
        .fence(fence),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .empty(empty),
        .count(count),
        .mem_access_addr(mem_access_addr),
        .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en),
        .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = dmem[mem_access_addr];

    always @(posedge clk) begin
        if (mem_write_en) dmem[mem_access_addr] <= mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic f,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        int            n;
        logic          blk;
        logic          ld;
        logic          hit;
        logic [DW-1:0] e_rd;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_we;
        logic          e_mr;
        logic          e_st;
        @(negedge clk);
        rst = 1'b0;
        cpu_read = r;
        cpu_write = w;
        fence = f;
        cpu_addr = a;
        cpu_wdata = d;
        #1;
        n = q.size();
        blk = f && n != 0;
        ld = r && !blk;
        hit = 1'b0;
        e_rd = '0;
        e_addr = '0;
        e_wd = '0;
        e_we = 1'b0;
        e_mr = 1'b0;
        if (ld) begin
            foreach (q[i]) begin
                if (q[i].a == a) begin
                    hit = 1'b1;
                    e_rd = q[i].d;
                end
            end
            if (!hit) begin
                e_addr = a;
                e_mr = 1'b1;
                e_rd = ref_mem[a];
            end
        end else if (n > 0) begin
            e_we = 1'b1;
            e_addr = q[0].a;
            e_wd = q[0].d;
        end
        e_st = (w && n == DEPTH) || (r && w) || ((r || w) && f && n != 0);
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("stall", 32'(cpu_stall), 32'(e_st));
        chk("rdata", 32'(cpu_rdata), 32'(e_rd));
        chk("maddr", 32'(mem_access_addr), 32'(e_addr));
        chk("mwdata", 32'(mem_write_data), 32'(e_wd));
        chk("mwe", 32'(mem_write_en), 32'(e_we));
        chk("mread", 32'(mem_read), 32'(e_mr));
        if (e_we) begin
            ref_mem[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (w && !r && n < DEPTH && !blk) q.push_back('{a, d});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        fence = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        #1;
        chk("rst_mwe", 32'(mem_write_en), 32'd0);
        q.delete();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = '0;
            dmem[i] = '0;
        end
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = DW'($urandom);
            dmem[i] = ref_mem[i];
        end
        ref_mem[9] = 16'h0042;
        dmem[9] = 16'h0042;

        do_reset();
        step(0, 0, 0, 0, 0);
        chk("rst_empty", 32'(empty), 32'd1);
        step(0, 1, 0, 16'd1, 16'd2);
        step(0, 0, 0, 0, 0);
        chk("tp_drain_we", 32'(mem_write_en), 32'd1);
        chk("tp_drain_addr", 32'(mem_access_addr), 32'd1);
        chk("tp_drain_data", 32'(mem_write_data), 32'd2);
        step(0, 0, 0, 0, 0);
        chk("tp_drained", 32'(empty), 32'd1);

        step(0, 1, 0, 16'd5, 16'hAAAA);
        step(1, 0, 0, 16'd5, 0);
        chk("tp_fwd", 32'(cpu_rdata), 32'h0000AAAA);
        chk("tp_fwd_mrd", 32'(mem_read), 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 16'd5, 16'h1111);
        step(0, 1, 0, 16'd5, 16'h2222);
        step(1, 0, 0, 16'd5, 0);
        chk("tp_young", 32'(cpu_rdata), 32'h00002222);
        repeat (3) step(0, 0, 0, 0, 0);

        step(1, 0, 0, 16'd9, 0);
        chk("tp_miss_rd", 32'(mem_read), 32'd1);
        chk("tp_miss_data", 32'(cpu_rdata), 32'h00000042);

        step(0, 1, 0, 16'd3, 16'h3333);
        step(1, 0, 0, 16'd20, 0);
        step(0, 1, 1, 16'd4, 16'h4444);
        chk("tp_fence_stall", 32'(cpu_stall), 32'd1);
        step(0, 1, 1, 16'd4, 16'h4444);
        chk("tp_fence_acc", 32'(cpu_stall), 32'd0);
        step(1, 1, 0, 16'd4, 16'h5555);
        chk("tp_rw_stall", 32'(cpu_stall), 32'd1);

        step(0, 1, 0, 16'd6, 16'h6666);
        do_reset();
        step(0, 0, 0, 0, 0);
        chk("tp_rst_cnt", 32'(count), 32'd0);
        chk("tp_rst_we", 32'(mem_write_en), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 5,
                     $urandom_range(0, 9) == 0, AW'($urandom_range(0, 15)),
                     DW'($urandom));
            end
        end
        repeat (DEPTH + 2) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            chk("final_mem", 32'(dmem[i]), 32'(ref_mem[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the MEM-stage load/store path and DataMem.
- Accepts CPU stores into a small FIFO and drains them into DataMem in cycles with no load.
- Forwards buffered store data to younger loads to the same address.
- Decouples store issue from the DataMem write port.
- Produces exactly the DataMem port signals: mem_access_addr, mem_write_data, mem_write_en, mem_read, mem_read_data.

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2.
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  AW  load/store word address.
- cpu_wdata  in  DW  store data.
- cpu_write  in  1  store request.
- cpu_read  in  1  load request.
- fence  in  1  drain-all request; blocks new CPU requests until the buffer is empty.
- cpu_rdata  out  DW  load data, combinational, same cycle as cpu_read.
- cpu_stall  out  1  request not accepted this cycle; CPU holds its request.
- empty  out  1  no stores pending.
- count  out  clog2(DEPTH)+1  number of pending stores.
- mem_access_addr  out  AW  to DataMem.
- mem_write_data  out  DW  to DataMem.
- mem_write_en  out  1  to DataMem; the write commits at that rising edge.
- mem_read  out  1  to DataMem.
- mem_read_data  in  DW  from DataMem; combinational read of mem_access_addr.

Behaviour:
- State:
  - DEPTH entries {addr, data}.
  - head and tail pointers, clog2(DEPTH) bits, wrap modulo DEPTH.
  - count register.
- Reset (rst=1 at an edge):
  - head, tail and count go to 0; all entries are invalid.
  - Pending stores are discarded, including a reset mid-drain.
  - Outputs after reset: empty=1, count=0, cpu_stall=0.
  - mem_write_en=0, mem_read=0, mem_access_addr=0, mem_write_data=0.
  - cpu_rdata=0 when no load is active.
- Port arbitration, evaluated combinationally each cycle in this priority:
  1. Load: cpu_read=1 and not fence-blocked.
     - Compare cpu_addr against all valid entries; the youngest match (nearest tail) wins.
     - Hit: cpu_rdata = entry data; mem_read=0; DataMem port idle.
     - Miss: mem_access_addr=cpu_addr, mem_read=1, cpu_rdata=mem_read_data.
     - The load completes in the same cycle with no stall.
     - No drain occurs in a load cycle.
  2. Drain: no load, count>0.
     - mem_access_addr=head.addr, mem_write_data=head.data, mem_write_en=1.
     - head increments at the edge.
  3. Idle: all mem outputs are 0.
- Store enqueue:
  - Condition: cpu_write=1, cpu_read=0, count<DEPTH, not fence-blocked.
  - Writes {cpu_addr, cpu_wdata} at tail at the edge; tail increments.
  - Stores to an address already buffered are appended, not coalesced.
- Stall:
  - cpu_stall = (cpu_write & count==DEPTH) | (cpu_read & cpu_write) | ((cpu_read|cpu_write) & fence & count!=0).
  - A stalled request has no effect on state.
  - When both cpu_read and cpu_write are set, the read is serviced and the write stalls; the CPU must not do this, but the outcome is defined.
- Fence:
  - While fence=1 and count>0, drain runs every cycle and CPU requests stall.
  - Once count=0, requests are accepted normally.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance.
  - Drain uses the old head. A store entering at tail==head when count=0 is not drained in the same cycle; earliest drain is the next cycle.
- Full: count=DEPTH blocks stores only; loads and forwarding continue.
- Ordering: stores reach DataMem in FIFO order; no load ever returns data older than a buffered store.
- Derived outputs: empty = (count==0). count is registered.

Test Plan:
- Reset, then store addr=1 data=2 with no loads.
  - Enqueue edge: count=1.
  - Next cycle: mem_write_en=1, mem_access_addr=1, mem_write_data=2.
  - Following cycle: count=0, empty=1.
- Store addr=5 data=0xAAAA, then load addr=5 in the next cycle (cpu_read held).
  - cpu_rdata=0xAAAA, mem_read=0.
  - Repeat with stores 5/0x1111 then 5/0x2222: load returns 0x2222 (youngest).
- Load miss: DataMem preloaded with addr=9 holding 0x0042, buffer empty, cpu_read=1 addr=9.
  - mem_read=1, mem_access_addr=9, cpu_rdata=0x0042 in the same cycle.
- Fill while cpu_read=1 on an unrelated address blocks drain.
  - 4 stores fill the buffer; count=4.
  - 5th store: cpu_stall=1, count stays 4.
  - Drop cpu_read: a drain occurs, the 5th store is accepted, count=4.
  - Verify DataMem receives writes in issue order; pointers wrap correctly through 8+ stores.
- Fence with count=3 and cpu_write held.
  - cpu_stall=1 for 3 cycles during 3 drains.
  - Store is accepted in the cycle count=0; no DataMem writes are lost.
- rst asserted with count=2 during a drain.
  - Next cycle: count=0, empty=1, all mem outputs 0.
  - Discarded entries are never written to DataMem.
